// File: rtl/act_pkg.sv
// Shared types and constants for the multi-lane activation unit.
package act_pkg;

  typedef enum logic [1:0] {
    ACT_SILU   = 2'd0,
    ACT_RELU   = 2'd1,
    ACT_LEAKY  = 2'd2,
    ACT_BYPASS = 2'd3
  } act_mode_e;

  localparam int LEAKY_SHIFT = 3;
  localparam int HSIG_SHIFT  = 2;

endpackage

// File: rtl/act_lane.sv
// One activation lane: S1 captures x/mode and the hard sigmoid, S2 forms x*s,
// S3 selects the activated result. Each stage loads only on its enable.
module act_lane
  import act_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en1,
  input  logic                         en2,
  input  logic                         en3,
  input  logic signed [DATA_WIDTH-1:0] x,
  input  act_mode_e                    mode,
  output logic signed [DATA_WIDTH-1:0] y
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam logic signed [DATA_WIDTH:0] ONE =
    {{(DATA_WIDTH-FRAC_BITS){1'b0}}, 1'b1, {FRAC_BITS{1'b0}}};
  localparam logic signed [DATA_WIDTH:0] HALF =
    {{(DATA_WIDTH-FRAC_BITS+1){1'b0}}, 1'b1, {(FRAC_BITS-1){1'b0}}};

  logic signed [DATA_WIDTH:0]   s_raw, s_next, s1;
  logic signed [DATA_WIDTH-1:0] x1, x2, y_next;
  logic signed [PW-1:0]         p2;
  act_mode_e                    m1, m2;
  logic                         unused_p;

  // Hard sigmoid x/4 + 0.5, one bit wider than x so the offset cannot overflow.
  always_comb begin
    s_raw  = {x[DATA_WIDTH-1], x >>> HSIG_SHIFT} + HALF;
    s_next = s_raw;
    if (s_raw[DATA_WIDTH])  s_next = '0;
    else if (s_raw > ONE)   s_next = ONE;
  end

  always_comb begin
    y_next = x2;
    case (m2)
      ACT_SILU:  y_next = p2[FRAC_BITS +: DATA_WIDTH];
      ACT_RELU:  y_next = x2[DATA_WIDTH-1] ? '0 : x2;
      ACT_LEAKY: y_next = x2[DATA_WIDTH-1] ? (x2 >>> LEAKY_SHIFT) : x2;
      default:   y_next = x2;
    endcase
  end

  // NOTE: datapath registers are reset too, so out_data reads 0 during and after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x1 <= '0;
      s1 <= '0;
      m1 <= ACT_SILU;
      x2 <= '0;
      p2 <= '0;
      m2 <= ACT_SILU;
      y  <= '0;
    end else begin
      if (en1) begin
        x1 <= x;
        s1 <= s_next;
        m1 <= mode;
      end
      if (en2) begin
        x2 <= x1;
        p2 <= PW'(x1) * PW'(s1);
        m2 <= m1;
      end
      if (en3) y <= y_next;
    end
  end

  // |x*s| >> F never exceeds |x|, so only the middle slice of the product is used.
  assign unused_p = ^{p2[PW-1:FRAC_BITS+DATA_WIDTH], p2[FRAC_BITS-1:0]};

endmodule

// File: rtl/act_lane_array.sv
// LANES-wide 3-stage activation pipeline with valid/ready flow control.
// Optional beat counter (stat_clr/stat_beats) when ACT_STATS_EN is defined.
module act_lane_array
  import act_pkg::*;
#(
  parameter int LANES      = 4,
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [LANES*DATA_WIDTH-1:0] in_data,
  input  logic [1:0]                  in_mode,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [LANES*DATA_WIDTH-1:0] out_data,
  output logic                        out_valid,
  input  logic                        out_ready
`ifdef ACT_STATS_EN
  ,
  input  logic                        stat_clr,
  output logic [31:0]                 stat_beats
`endif
);

  logic v1, v2, v3;
  logic en1, en2, en3;

  // NOTE: enables chain back from the output only; in_valid never reaches in_ready.
  assign en3      = !v3 || out_ready;
  assign en2      = !v2 || en3;
  assign en1      = !v1 || en2;
  assign in_ready = en1;
  assign out_valid = v3;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else begin
      if (en1) v1 <= in_valid;
      if (en2) v2 <= v1;
      if (en3) v3 <= v2;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    act_lane #(
      .DATA_WIDTH(DATA_WIDTH),
      .FRAC_BITS (FRAC_BITS)
    ) u_lane (
      .clk  (clk),
      .reset(reset),
      .en1  (en1),
      .en2  (en2),
      .en3  (en3),
      .x    (in_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .mode (act_mode_e'(in_mode)),
      .y    (out_data[i*DATA_WIDTH +: DATA_WIDTH])
    );
  end

`ifdef ACT_STATS_EN
  logic [31:0] stat_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                      stat_q <= '0;
    else if (stat_clr)               stat_q <= '0;
    else if (out_valid && out_ready) stat_q <= stat_q + 32'd1;
  end

  assign stat_beats = stat_q;
`endif

endmodule

// File: tb/tb_act_lane_array.sv
// Directed and randomised checks of act_lane_array in Q8.8 with four lanes.
module tb_act_lane_array;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] in_data;
  logic [1:0]  in_mode;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_ready;
`ifdef ACT_STATS_EN
  logic        stat_clr;
  logic [31:0] stat_beats;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [63:0] data;
    logic [1:0]  mode;
  } beat_t;

  beat_t       src_q[$];
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  act_lane_array #(.LANES(4), .DATA_WIDTH(16), .FRAC_BITS(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef ACT_STATS_EN
    ,
    .stat_clr  (stat_clr),
    .stat_beats(stat_beats)
`endif
  );

  // Reference: hard-sigmoid SiLU, ReLU, leaky slope 1/8, bypass, all in integer math.
  function automatic logic [15:0] ref_lane(input logic [15:0] xin, input logic [1:0] m);
    int x, s, y;
    x = int'($signed(xin));
    case (m)
      2'd0: begin
        s = (x >>> 2) + 128;
        if (s < 0)   s = 0;
        if (s > 256) s = 256;
        y = (x * s) >>> 8;
      end
      2'd1:    y = (x < 0) ? 0 : x;
      2'd2:    y = (x < 0) ? (x >>> 3) : x;
      default: y = x;
    endcase
    return y[15:0];
  endfunction

  function automatic logic [63:0] ref_beat(input beat_t b);
    logic [63:0] r;
    for (int i = 0; i < 4; i++) r[i*16 +: 16] = ref_lane(b.data[i*16 +: 16], b.mode);
    return r;
  endfunction

  // Streams src_q through the DUT. vmode: 0 = always valid, 1 = random valid.
  // rmode: 0 = always ready, 1 = random ready, 2 = out_ready low for cycles 4-9.
  task automatic stream(input int vmode, input int rmode, input int max_cycles,
                        output int cycles, output int full_cycles);
    int          cyc = 0;
    int          occ = 0;
    logic        prev_stall = 1'b0;
    logic [63:0] prev_data = '0;
    logic        exp_ready;
    full_cycles = 0;
    while ((src_q.size() > 0 || exp_q.size() > 0) && cyc < max_cycles) begin
      @(negedge clk);
      in_valid = (src_q.size() > 0) && (vmode == 0 || $urandom_range(0, 1) == 1);
      if (src_q.size() > 0) begin
        in_data = src_q[0].data;
        in_mode = src_q[0].mode;
      end
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 1) == 1);
        default: out_ready = !(cyc >= 4 && cyc <= 9);
      endcase
      #1;
      exp_ready = (occ < 3) || out_ready;
      total++;
      if (in_ready !== exp_ready) begin
        bad++;
        $display("FAIL in_ready cyc=%0d occ=%0d got=%b want=%b", cyc, occ, in_ready, exp_ready);
      end
      if (!in_ready) full_cycles++;
      if (prev_stall) begin
        total++;
        if (out_valid !== 1'b1 || out_data !== prev_data) begin
          bad++;
          $display("FAIL hold cyc=%0d got=%b/%h want=1/%h", cyc, out_valid, out_data, prev_data);
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_beat(src_q[0]));
        void'(src_q.pop_front());
        occ++;
      end
      if (out_valid && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL extra_beat cyc=%0d got=%h want=none", cyc, out_data);
        end else begin
          if (out_data !== exp_q[0]) begin
            bad++;
            $display("FAIL stream_data cyc=%0d got=%h want=%h", cyc, out_data, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
        occ--;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      cyc++;
    end
    total++;
    if (src_q.size() > 0 || exp_q.size() > 0) begin
      bad++;
      $display("FAIL stream_timeout pending_in=%0d pending_out=%0d want=0/0",
               src_q.size(), exp_q.size());
      src_q.delete();
      exp_q.delete();
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    cycles = cyc;
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_mode   = 2'd0;
    out_ready = 1'b0;
`ifdef ACT_STATS_EN
    stat_clr  = 1'b0;
`endif
    #1;
    total++;
    if (out_valid !== 1'b0 || out_data !== 64'h0) begin
      bad++;
      $display("FAIL reset_out got=%b/%h want=0/0", out_valid, out_data);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready got=%b want=1", in_ready);
    end
  endtask

  // Single SiLU beat; checks out_valid rises exactly on the third edge.
  task automatic test_silu();
    @(negedge clk);
    in_data   = {16'hF800, 16'h0400, 16'hFF00, 16'h0100};
    in_mode   = 2'd0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      total++;
      if (out_valid !== (i == 3)) begin
        bad++;
        $display("FAIL silu_latency edge=%0d got=%b want=%b", i, out_valid, (i == 3));
      end
    end
    total++;
    if (out_data !== {16'h0000, 16'h0400, 16'hFFC0, 16'h00C0}) begin
      bad++;
      $display("FAIL silu_data got=%h want=%h", out_data, {16'h0000, 16'h0400, 16'hFFC0, 16'h00C0});
    end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // Back-to-back beats of -1.0 with the mode changing every beat.
  task automatic test_modes();
    logic [1:0]  modes[4];
    logic [63:0] want[4];
    modes = '{2'd1, 2'd2, 2'd3, 2'd0};
    want  = '{64'h0000_0000_0000_0000, 64'hFFE0_FFE0_FFE0_FFE0,
              64'hFF00_FF00_FF00_FF00, 64'hFFC0_FFC0_FFC0_FFC0};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = (i < 4);
      in_data   = 64'hFF00_FF00_FF00_FF00;
      in_mode   = modes[i % 4];
      #1;
      if (i >= 3) begin
        total++;
        if (out_valid !== 1'b1 || out_data !== want[i-3]) begin
          bad++;
          $display("FAIL mode_beat%0d got=%b/%h want=1/%h", i - 3, out_valid, out_data, want[i-3]);
        end
      end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_back_pressure();
    logic [15:0] vals[10];
    int cycles, full;
    vals = '{16'h0100, 16'hFF00, 16'h0380, 16'hFC00, 16'h7FFF,
             16'h8000, 16'h0040, 16'hFFF8, 16'h1234, 16'hEDCB};
    for (int i = 0; i < 10; i++) begin
      beat_t b;
      b.data = {4{vals[i]}};
      b.mode = 2'(i);
      src_q.push_back(b);
    end
    stream(0, 2, 100, cycles, full);
    total++;
    if (full == 0) begin
      bad++;
      $display("FAIL bp_in_ready_low got=%0d want>0", full);
    end
  endtask

  task automatic test_throughput();
    int cycles, full;
    for (int i = 0; i < 20; i++) begin
      beat_t b;
      b.data = {$urandom(), $urandom()};
      b.mode = 2'($urandom_range(0, 3));
      src_q.push_back(b);
    end
    stream(0, 0, 200, cycles, full);
    total++;
    if (cycles != 23) begin
      bad++;
      $display("FAIL throughput cycles got=%0d want=23", cycles);
    end
  endtask

  task automatic test_random();
    int cycles, full;
    for (int i = 0; i < 3000; i++) begin
      beat_t b;
      b.data = {$urandom(), $urandom()};
      b.mode = 2'($urandom_range(0, 3));
      src_q.push_back(b);
    end
    stream(1, 1, 30000, cycles, full);
  endtask

  // Reset with three beats held; then a fresh beat must come out cleanly.
  task automatic test_reset_midstream();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = {4{16'h0200 + 16'(i)}};
      in_mode   = 2'd3;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL rst_pre_full got=%b/%b want=1/0", out_valid, in_ready);
    end
    reset = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_data !== 64'h0) begin
      bad++;
      $display("FAIL rst_async got=%b/%h want=0/0", out_valid, out_data);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    in_data   = {4{16'h0100}};
    in_mode   = 2'd0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      total++;
      if (out_valid !== (i == 3)) begin
        bad++;
        $display("FAIL rst_new_latency edge=%0d got=%b want=%b", i, out_valid, (i == 3));
      end
      if (i == 3) begin
        total++;
        if (out_data !== {4{16'h00C0}}) begin
          bad++;
          $display("FAIL rst_new_data got=%h want=%h", out_data, {4{16'h00C0}});
        end
      end
    end
    out_ready = 1'b0;
  endtask

`ifdef ACT_STATS_EN
  task automatic test_stats();
    int cycles, full;
    @(negedge clk);
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    total++;
    if (stat_beats !== 32'd0) begin
      bad++;
      $display("FAIL stat_clear got=%h want=0", stat_beats);
    end
    for (int i = 0; i < 5; i++) begin
      beat_t b;
      b.data = {4{16'(i)}};
      b.mode = 2'd3;
      src_q.push_back(b);
    end
    stream(0, 0, 100, cycles, full);
    total++;
    if (stat_beats !== 32'd5) begin
      bad++;
      $display("FAIL stat_five got=%h want=5", stat_beats);
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = '0;
    in_mode  = 2'd3;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    out_ready = 1'b1;
    stat_clr  = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    stat_clr  = 1'b0;
    total++;
    if (stat_beats !== 32'd0) begin
      bad++;
      $display("FAIL stat_clr_priority got=%h want=0", stat_beats);
    end
    force dut.stat_q = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut.stat_q;
    for (int k = 0; k < 2; k++) begin
      beat_t b;
      logic [31:0] want;
      want   = (k == 0) ? 32'hFFFF_FFFF : 32'h0;
      b.data = '1;
      b.mode = 2'd1;
      src_q.push_back(b);
      stream(0, 0, 100, cycles, full);
      total++;
      if (stat_beats !== want) begin
        bad++;
        $display("FAIL stat_wrap%0d got=%h want=%h", k, stat_beats, want);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_silu();
    test_modes();
    test_back_pressure();
    test_throughput();
    test_random();
    test_reset_midstream();
`ifdef ACT_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
